mult_sequencer: RTL

Control FSM that sequences the 8-bit signed add-shift multiplier datapath. The datapath has an A/B shift register pair, an X sign flop, and add and subtract adders. This block replaces ad-hoc control with a counted, handshaked sequencer. It issues one clear/load, then N add-or-subtract/shift step pairs, then holds a result-valid state until Run is released. It sits between the debounced, active-high button requests and the register load/shift enables at the multiplier top level.

---
 rtl/mult_sequencer_pkg.sv | 29 ++
 rtl/mult_sequencer_if.sv | 24 ++
 rtl/mult_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared types for the add-shift multiplier sequencer: state encoding,
// default operand width and the one-hot datapath strobe bundle.
package mult_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLR_A,
      S_ADD,
      S_SHIFT,
      S_HALT
   } state_t;

   localparam int N_BITS_DEFAULT = 8;

   typedef struct packed {
      logic clr_a;
      logic ld_b;
      logic add;
      logic sub;
      logic shift;
   } strobe_t;

   // Step counter width; a one-bit floor keeps degenerate widths legal.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Request / strobe bundle between the button front end, the sequencer
// and the multiplier datapath.
interface mult_sequencer_if;
   logic run;
   logic clr_ld_req;
   logic m;
   logic clr_a;
   logic ld_b;
   logic add;
   logic sub;
   logic shift;
   logic busy;
   logic done;

   modport master (
      output run, clr_ld_req, m,
      input  clr_a, ld_b, add, sub, shift, busy, done
   );

   modport slave (
      input  run, clr_ld_req, m,
      output clr_a, ld_b, add, sub, shift, busy, done
   );
endinterface

// File: rtl/mult_sequencer.sv
// Counted control FSM for the signed add-shift multiplier: one clear, then
// N add/sub + shift step pairs, then hold the result until Run is released.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting; Run starts a multiply, Clr_Ld_Req loads B
//   LOAD    | one-cycle Ld_B pulse, back to IDLE
//   CLR_A   | clear A/X, reset step counter
//   ADD     | Add (or Sub on the last step) when M=1
//   SHIFT   | arithmetic right shift of X:A:B, advance step counter
//   HALT    | result valid (Done); wait for Run=0
module mult_sequencer
   import mult_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   mult_sequencer_if.slave  bus
);

   localparam int            CW   = cnt_width(N_BITS);
   localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   strobe_t         w_stb;
   logic            w_last;

   assign w_last = (r_cnt == LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.run)
                  r_state <= S_CLR_A;
               else if (bus.clr_ld_req)
                  r_state <= S_LOAD;
            end
            S_LOAD: r_state <= S_IDLE;
            S_CLR_A: begin
               r_cnt   <= '0;
               r_state <= S_ADD;
            end
            S_ADD: r_state <= S_SHIFT;
            S_SHIFT: begin
               // Hold the counter on the final step so it never wraps.
               if (w_last) begin
                  r_state <= S_HALT;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= S_ADD;
               end
            end
            S_HALT: begin
               if (!bus.run)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Add/Sub follow M directly so the datapath sees B[0] of this step.
   always_comb begin
      w_stb = '0;
      case (r_state)
         S_LOAD:  w_stb.ld_b  = 1'b1;
         S_CLR_A: w_stb.clr_a = 1'b1;
         S_ADD: begin
            w_stb.add = bus.m & ~w_last;
            w_stb.sub = bus.m &  w_last;
         end
         S_SHIFT: w_stb.shift = 1'b1;
         default: w_stb = '0;
      endcase
   end

   assign bus.clr_a = w_stb.clr_a;
   assign bus.ld_b  = w_stb.ld_b;
   assign bus.add   = w_stb.add;
   assign bus.sub   = w_stb.sub;
   assign bus.shift = w_stb.shift;
   assign bus.busy  = (r_state == S_CLR_A) || (r_state == S_ADD) || (r_state == S_SHIFT);
   assign bus.done  = (r_state == S_HALT);

endmodule
